// File: rtl/alu_seq_checker.sv
// Monitor for the auto-sequencing 8-bit ALU: locks onto the SUM..SHR rotation, flags bad results or mistimed steps.
// Latency: pins to match 2 cycles, match to locked/op_est/err_pulse 1 more; no backpressure, ena=0 freezes all state.
module alu_seq_checker #(
   parameter int TICKS = 100_000_000,
   parameter int TOL   = 4,
   parameter int CNT_W = 27
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] r,
   output logic       locked,
   output logic [2:0] op_est,
   output logic       err_pulse,
   output logic [7:0] err_count,
   output logic [5:0] match
);

   localparam logic [0:0] ST_SEARCH = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   localparam logic [CNT_W-1:0] ADV_MIN   = CNT_W'(TICKS - 1 - TOL);
   localparam logic [CNT_W-1:0] ADV_FULL  = CNT_W'(TICKS - 1);
   localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(TICKS - 1 + TOL);

   function automatic logic is_onehot(input logic [5:0] v);
      return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
   endfunction

   function automatic logic [2:0] oh_to_idx(input logic [5:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 6; i++) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   logic [7:0]       a_q, a_d, b_q, b_d, r_q, r_d;
   logic [5:0]       match_q, match_d, prev_q, prev_d;
   logic [0:0]       state_q, state_d;
   logic [2:0]       op_est_q, op_est_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic             err_pulse_q, err_pulse_d;
   logic [7:0]       err_count_q, err_count_d;

   logic [7:0] ref_sum, ref_sub, ref_and, ref_or, ref_shl, ref_shr;
   logic [5:0] hit;
   logic [2:0] nxt;
   logic       acquire, advance, err;

   assign ref_sum = a_q + b_q;
   assign ref_sub = a_q - b_q;
   assign ref_and = a_q & b_q;
   assign ref_or  = a_q | b_q;
   assign ref_shl = {a_q[6:0], 1'b0};
   assign ref_shr = {1'b0, a_q[7:1]};

   assign hit = {r_q == ref_shr, r_q == ref_shl, r_q == ref_or,
                 r_q == ref_and, r_q == ref_sub, r_q == ref_sum};

   assign nxt = (op_est_q == 3'd5) ? 3'd0 : op_est_q + 3'd1;

   // Two consecutive unique matches one step apart in the rotation prove we saw a real boundary.
   assign acquire = is_onehot(prev_q) && (match_q == {prev_q[4:0], prev_q[5]});

   // While the current op still matches (ambiguous operands), only step once the full dwell has elapsed.
   assign advance = match_q[nxt] && (dwell_q >= ADV_MIN) &&
                    (!match_q[op_est_q] || (dwell_q >= ADV_FULL));

   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      r_d         = r_q;
      match_d     = match_q;
      prev_d      = prev_q;
      state_d     = state_q;
      op_est_d    = op_est_q;
      dwell_d     = dwell_q;
      err         = 1'b0;
      err_pulse_d = 1'b0;
      err_count_d = err_count_q;
      if (ena) begin
         a_d     = a;
         b_d     = b;
         r_d     = r;
         match_d = hit;
         prev_d  = match_q;
         if (state_q == ST_SEARCH) begin
            if (acquire) begin
               state_d  = ST_LOCKED;
               op_est_d = oh_to_idx(match_q);
               dwell_d  = '0;
            end
         end else if (advance) begin
            op_est_d = nxt;
            dwell_d  = '0;
         end else if (!match_q[op_est_q] || (dwell_q == DWELL_MAX)) begin
            err     = 1'b1;
            state_d = ST_SEARCH;
            dwell_d = '0;
         end else begin
            dwell_d = dwell_q + CNT_W'(1);
         end
         err_pulse_d = err;
         if (err && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q         <= '0;
         b_q         <= '0;
         r_q         <= '0;
         match_q     <= '0;
         prev_q      <= '0;
         state_q     <= ST_SEARCH;
         op_est_q    <= '0;
         dwell_q     <= '0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         r_q         <= r_d;
         match_q     <= match_d;
         prev_q      <= prev_d;
         state_q     <= state_d;
         op_est_q    <= op_est_d;
         dwell_q     <= dwell_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
      end
   end

   assign locked    = (state_q == ST_LOCKED);
   assign op_est    = op_est_q;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;
   assign match     = match_q;

endmodule

// File: tb/tb_alu_seq_checker.sv
// Directed bench for alu_seq_checker with TICKS=10, TOL=1: period table plus hand-written corner sequences.
module tb_alu_seq_checker;

   localparam int TICKS = 10;
   localparam int TOL   = 1;
   localparam int CNT_W = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic [7:0] a = 8'h00, b = 8'h00, r = 8'h00;
   logic       locked, err_pulse;
   logic [2:0] op_est;
   logic [7:0] err_count;
   logic [5:0] match;

   alu_seq_checker #(.TICKS(TICKS), .TOL(TOL), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .a(a), .b(b), .r(r),
      .locked(locked), .op_est(op_est), .err_pulse(err_pulse),
      .err_count(err_count), .match(match)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int pulses = 0;

   always @(negedge clk) if (err_pulse) pulses++;

   typedef struct {
      int         op;
      logic [7:0] a;
      logic [7:0] b;
      int         len;
      int         glitch;
      int         e_locked;
      int         e_op;
      int         e_err;
   } vec_t;

   vec_t tv[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] alu_ref(input int op, input logic [7:0] x, input logic [7:0] y);
      case (op)
         0:       return x + y;
         1:       return x - y;
         2:       return x & y;
         3:       return x | y;
         4:       return {x[6:0], 1'b0};
         default: return {1'b0, x[7:1]};
      endcase
   endfunction

   task automatic cyc(input logic [7:0] rr);
      r = rr;
      @(posedge clk);
      #1;
   endtask

   task automatic run_period(input int op, input logic [7:0] aa, input logic [7:0] bb,
                             input int len, input int glitch);
      a = aa;
      b = bb;
      for (int i = 0; i < len; i++) cyc((glitch != 0 && i == 4) ? 8'h00 : alu_ref(op, aa, bb));
   endtask

   task automatic add(input int op, input logic [7:0] aa, input logic [7:0] bb, input int len,
                      input int gl, input int el, input int eo, input int ee);
      vec_t v;
      v.op = op; v.a = aa; v.b = bb; v.len = len; v.glitch = gl;
      v.e_locked = el; v.e_op = eo; v.e_err = ee;
      tv.push_back(v);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int k;
      int p0;
      int rot[6];
      rot = '{2, 3, 4, 5, 0, 1};

      for (int rep = 0; rep < 3; rep++)
         for (int j = 0; j < 6; j++) add(rot[j], 8'h3C, 8'h15, 10, 0, 1, rot[j], 0);
      // R forced to 0 mid-OR, then re-lock on SHL
      add(2, 8'h3C, 8'h15, 10, 0, 1, 2, 0);
      add(3, 8'h3C, 8'h15, 10, 1, 0, 3, 1);
      add(4, 8'h3C, 8'h15, 10, 0, 1, 4, 1);
      add(5, 8'h3C, 8'h15, 10, 0, 1, 5, 1);
      add(0, 8'h3C, 8'h15, 10, 0, 1, 0, 1);
      // SUB lasts only 7 cycles: early step into AND, op_est holds SUB
      add(1, 8'h3C, 8'h15, 7,  0, 1, 1, 1);
      add(2, 8'h3C, 8'h15, 10, 0, 0, 1, 2);
      add(3, 8'h3C, 8'h15, 10, 0, 1, 3, 2);
      // late step at 11 cycles is tolerated
      add(4, 8'h3C, 8'h15, 11, 0, 1, 4, 2);
      add(5, 8'h3C, 8'h15, 10, 0, 1, 5, 2);
      // SUM stalls 12 cycles: timeout, then immediate re-lock at SUB
      add(0, 8'h3C, 8'h15, 12, 0, 1, 0, 2);
      add(1, 8'h3C, 8'h15, 10, 0, 1, 1, 3);
      for (int j = 0; j < 6; j++) add(rot[j], 8'h55, 8'h55, 10, 0, 1, rot[j], 3);
      add(2, 8'h55, 8'h55, 10, 0, 1, 2, 3);

      // reset state
      #3;
      check("rst_locked", 32'(locked), 0);
      check("rst_op_est", 32'(op_est), 0);
      check("rst_err_pulse", 32'(err_pulse), 0);
      check("rst_err_count", 32'(err_count), 0);
      check("rst_match", 32'(match), 0);

      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ena   = 1'b1;

      // acquisition at the first SUM->SUB boundary
      run_period(0, 8'h3C, 8'h15, 10, 0);
      check("pre_acq_locked", 32'(locked), 0);
      k = 0;
      while (!locked && k < 6) begin
         cyc(alu_ref(1, 8'h3C, 8'h15));
         k++;
      end
      check("acq_locked", 32'(locked), 1);
      check("acq_op_est", 32'(op_est), 1);
      check("acq_latency", 32'(k >= 2 && k <= 3), 1);
      for (int i = k; i < 10; i++) cyc(alu_ref(1, 8'h3C, 8'h15));
      check("acq_err_count", 32'(err_count), 0);

      foreach (tv[i]) begin
         run_period(tv[i].op, tv[i].a, tv[i].b, tv[i].len, tv[i].glitch);
         check($sformatf("vec%0d_locked", i), 32'(locked), tv[i].e_locked);
         check($sformatf("vec%0d_op_est", i), 32'(op_est), tv[i].e_op);
         check($sformatf("vec%0d_err_count", i), 32'(err_count), tv[i].e_err);
         check($sformatf("vec%0d_pulses", i), pulses, tv[i].e_err);
      end

      // ena low for 5 cycles mid-OR with the ALU paused
      a = 8'h3C;
      b = 8'h15;
      for (int i = 0; i < 4; i++) cyc(alu_ref(3, a, b));
      ena = 1'b0;
      check("ena_pre_op_est", 32'(op_est), 3);
      for (int i = 0; i < 5; i++) cyc(alu_ref(3, a, b));
      check("ena_hold_locked", 32'(locked), 1);
      check("ena_hold_op_est", 32'(op_est), 3);
      check("ena_hold_err_pulse", 32'(err_pulse), 0);
      ena = 1'b1;
      for (int i = 0; i < 6; i++) cyc(alu_ref(3, a, b));
      run_period(4, 8'h3C, 8'h15, 10, 0);
      check("ena_after_locked", 32'(locked), 1);
      check("ena_after_op_est", 32'(op_est), 4);
      check("ena_after_err_count", 32'(err_count), 3);
      check("ena_after_pulses", pulses, 3);

      // asynchronous reset mid-SHR while locked
      run_period(5, 8'h3C, 8'h15, 5, 0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_locked", 32'(locked), 0);
      check("mid_rst_op_est", 32'(op_est), 0);
      check("mid_rst_err_count", 32'(err_count), 0);
      check("mid_rst_match", 32'(match), 0);
      check("mid_rst_err_pulse", 32'(err_pulse), 0);
      @(posedge clk);
      #1;
      cyc(alu_ref(5, a, b));
      rst_n = 1'b1;
      run_period(5, 8'h3C, 8'h15, 5, 0);
      check("post_rst_unlocked", 32'(locked), 0);
      run_period(0, 8'h3C, 8'h15, 10, 0);
      check("relock_locked", 32'(locked), 1);
      check("relock_op_est", 32'(op_est), 0);
      check("relock_err_count", 32'(err_count), 0);

      // OR, SHL, bad pattern: one lock and one error per 3 cycles
      p0 = pulses;
      for (int i = 0; i < 300; i++) begin
         cyc(alu_ref(3, a, b));
         cyc(alu_ref(4, a, b));
         cyc(8'h00);
      end
      for (int i = 0; i < 3; i++) cyc(8'h00);
      check("sat_err_count", 32'(err_count), 255);
      check("sat_pulses", pulses - p0, 301);
      check("sat_locked", 32'(locked), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
